// File: rtl/writeburst_avalon_responder_pkg.sv
// writeburst_avalon_responder_pkg: shared state encoding, dword type and burst-length clip.
package writeburst_avalon_responder_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BEAT0 = 3'd1,
        BEAT1 = 3'd2,
        DONE  = 3'd3,
        GUARD = 3'd4
    } state_t;

    typedef logic [31:0] dword_t;

    // A request of 3 dwords cannot fit a 56-bit payload; it is issued as 2 beats.
    function automatic logic [1:0] clip_burst(input logic [1:0] len);
        return (len == 2'd1) ? 2'd1 : 2'd2;
    endfunction
endpackage

// File: rtl/writeburst_lane_align.sv
// writeburst_lane_align: place 56-bit request data onto byte lanes starting at the address offset.
//   offset : address[1:0], lane of payload byte 0
//   data   : 56-bit payload, byte 0 least significant
//   dw0/dw1: first and second dword of the aligned 64-bit window
module writeburst_lane_align
    import writeburst_avalon_responder_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [55:0] data,
    output dword_t      dw0,
    output dword_t      dw1
);
    logic [63:0] wide;

    // Bytes shifted past lane 7 are dropped; at most 7 payload bytes exist.
    assign wide = {8'h00, data} << {offset, 3'b000};
    assign dw0  = wide[31:0];
    assign dw1  = wide[63:32];
endmodule

// File: rtl/writeburst_avalon_responder.sv
// writeburst_avalon_responder: issue one writeburst request as a 1- or 2-beat Avalon-MM write burst.
//   clk, rst_n            : clock, asynchronous active-low reset
//   writeburst_*          : link request (do held until done) and one-cycle done pulse
//   avm_*                 : registered Avalon-MM master write port, avm_waitrequest stalls
module writeburst_avalon_responder
    import writeburst_avalon_responder_pkg::*;
#(
    parameter int GUARD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        writeburst_do,
    output logic        writeburst_done,
    input  logic [31:0] writeburst_address,
    input  logic [1:0]  writeburst_dword_length,
    input  logic [3:0]  writeburst_byteenable_0,
    input  logic [3:0]  writeburst_byteenable_1,
    input  logic [55:0] writeburst_data,
    output logic [29:0] avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    output logic [1:0]  avm_burstcount,
    input  logic        avm_waitrequest
);
    state_t     state;
    logic [1:0] guard_cnt;
    dword_t     dw0;
    dword_t     dw1;
    dword_t     dw1_q;
    logic [3:0] be1_q;
    logic       accept;

    writeburst_lane_align u_align (
        .offset(writeburst_address[1:0]),
        .data  (writeburst_data),
        .dw0   (dw0),
        .dw1   (dw1)
    );

    assign accept = avm_write & ~avm_waitrequest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            guard_cnt       <= 2'd0;
            dw1_q           <= '0;
            be1_q           <= 4'h0;
            writeburst_done <= 1'b0;
            avm_address     <= 30'd0;
            avm_write       <= 1'b0;
            avm_writedata   <= 32'd0;
            avm_byteenable  <= 4'h0;
            avm_burstcount  <= 2'd0;
        end else begin
            writeburst_done <= 1'b0;
            case (state)
                IDLE: if (writeburst_do) begin
                    dw1_q <= dw1;
                    be1_q <= writeburst_byteenable_1;
                    if (writeburst_dword_length == 2'd0) begin
                        state           <= DONE;
                        writeburst_done <= 1'b1;
                    end else begin
                        state          <= BEAT0;
                        avm_write      <= 1'b1;
                        avm_address    <= writeburst_address[31:2];
                        avm_writedata  <= dw0;
                        avm_byteenable <= writeburst_byteenable_0;
                        avm_burstcount <= clip_burst(writeburst_dword_length);
                    end
                end
                BEAT0, BEAT1: if (accept) begin
                    if (state == BEAT0 && avm_burstcount == 2'd2) begin
                        // Second beat keeps address and burstcount of the burst.
                        state          <= BEAT1;
                        avm_writedata  <= dw1_q;
                        avm_byteenable <= be1_q;
                    end else begin
                        state           <= DONE;
                        writeburst_done <= 1'b1;
                        avm_address     <= 30'd0;
                        avm_write       <= 1'b0;
                        avm_writedata   <= 32'd0;
                        avm_byteenable  <= 4'h0;
                        avm_burstcount  <= 2'd0;
                    end
                end
                DONE: begin
                    state     <= GUARD;
                    guard_cnt <= 2'd0;
                end
                GUARD: begin
                    // Swallows the link's do, which lingers one cycle past done.
                    if (guard_cnt == 2'(GUARD_CYCLES - 1)) state <= IDLE;
                    else guard_cnt <= guard_cnt + 2'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_writeburst_avalon_responder.sv
// tb_writeburst_avalon_responder: randomized scoreboard bench with a byte-level reference model.
module tb_writeburst_avalon_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_do = 1'b0;
    logic        wb_done;
    logic [31:0] wb_addr = '0;
    logic [1:0]  wb_len = '0;
    logic [3:0]  wb_be0 = '0;
    logic [3:0]  wb_be1 = '0;
    logic [55:0] wb_data = '0;
    logic [29:0] avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [1:0]  avm_burstcount;
    logic        waitreq = 1'b0;

    writeburst_avalon_responder #(.GUARD_CYCLES(1)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .writeburst_do          (wb_do),
        .writeburst_done        (wb_done),
        .writeburst_address     (wb_addr),
        .writeburst_dword_length(wb_len),
        .writeburst_byteenable_0(wb_be0),
        .writeburst_byteenable_1(wb_be1),
        .writeburst_data        (wb_data),
        .avm_address            (avm_address),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_byteenable         (avm_byteenable),
        .avm_burstcount         (avm_burstcount),
        .avm_waitrequest        (waitreq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [1:0]  bc;
        bit          last;
    } beat_t;

    typedef struct {
        int nbeats;
        int t_sample;
    } txn_t;

    beat_t beat_q[$];
    txn_t  txn_q[$];
    int    stall_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    stall_left = 0;
    bit    have_beat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: payload byte i lands at absolute byte address a+i; beat k covers dword (a>>2)+k.
    function automatic void model(input logic [31:0] a, input logic [1:0] len,
                                  input logic [3:0] b0, input logic [3:0] b1,
                                  input logic [55:0] d, input int t_sample);
        int    n;
        int    off;
        int    idx;
        beat_t b;
        txn_t  t;
        n   = (len == 0) ? 0 : (len == 1) ? 1 : 2;
        off = int'(a[1:0]);
        for (int k = 0; k < n; k++) begin
            b.data = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * k + j - off;
                if (idx >= 0 && idx < 7) b.data[8*j +: 8] = d[8*idx +: 8];
            end
            b.addr = a[31:2];
            b.be   = (k == 0) ? b0 : b1;
            b.bc   = 2'(n);
            b.last = (k == n - 1);
            beat_q.push_back(b);
        end
        t.nbeats   = n;
        t.t_sample = t_sample;
        txn_q.push_back(t);
    endfunction

    // Slave: each beat stalls for a preset number of cycles taken from stall_q.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && avm_write) begin
                if (!have_beat) begin
                    stall_left = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
                    have_beat  = 1;
                end
                if (stall_left > 0) begin
                    waitreq = 1'b1;
                    stall_left--;
                end else begin
                    waitreq   = 1'b0;
                    have_beat = 0;
                end
            end else waitreq = 1'b0;
        end
    end

    // Monitor: compares every accepted beat and done pulse against the scoreboard.
    initial begin
        logic        p_stall = 0;
        logic        p_write = 0;
        logic        p_done = 0;
        logic [29:0] p_addr = '0;
        logic [31:0] p_data = '0;
        logic [3:0]  p_be = '0;
        logic [1:0]  p_bc = '0;
        int          last_acc = -10;
        beat_t       e;
        txn_t        t;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_stall = 0;
                p_write = 0;
                p_done  = 0;
                continue;
            end
            if (!avm_write) chk("idle_bus_zero", {avm_address, avm_writedata, avm_byteenable, avm_burstcount}, '0);
            else begin
                if (p_stall) chk("stall_stable", {avm_address, avm_writedata, avm_byteenable, avm_burstcount},
                                 {p_addr, p_data, p_be, p_bc});
                if (!p_write) begin
                    if (txn_q.size() == 0) chk("write_without_request", 1, 0);
                    else chk("first_write_cycle", 64'(cyc), 64'(txn_q[0].t_sample));
                end
                if (!waitreq) begin
                    if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
                    else begin
                        e = beat_q.pop_front();
                        chk("beat_address", 64'(avm_address), 64'(e.addr));
                        chk("beat_writedata", 64'(avm_writedata), 64'(e.data));
                        chk("beat_byteenable", 64'(avm_byteenable), 64'(e.be));
                        chk("beat_burstcount", 64'(avm_burstcount), 64'(e.bc));
                        if (e.last) last_acc = cyc;
                    end
                end
            end
            if (wb_done) begin
                if (p_done) chk("done_single_cycle", 1, 0);
                if (txn_q.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    t = txn_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'((t.nbeats > 0) ? last_acc + 1 : t.t_sample));
                    chk("beats_left_at_done", 64'(beat_q.size()), 0);
                end
            end
            p_stall = avm_write & waitreq;
            p_write = avm_write;
            p_done  = wb_done;
            {p_addr, p_data, p_be, p_bc} = {avm_address, avm_writedata, avm_byteenable, avm_burstcount};
        end
    end

    // Called at posedge+1 with the responder idle; returns at posedge+1 two cycles after done.
    task automatic send(input logic [31:0] a, input logic [1:0] len, input logic [3:0] b0,
                        input logic [3:0] b1, input logic [55:0] d, input int s0, input int s1);
        bit seen = 0;
        model(a, len, b0, b1, d, cyc + 1);
        if (len != 0) stall_q.push_back(s0);
        if (len >= 2) stall_q.push_back(s1);
        {wb_addr, wb_len, wb_be0, wb_be1, wb_data} = {a, len, b0, b1, d};
        wb_do = 1'b1;
        @(posedge clk);
        #1;
        {wb_addr, wb_be0, wb_be1} = {$urandom, 4'($urandom), 4'($urandom)};
        wb_len  = 2'($urandom);
        wb_data = {24'($urandom), $urandom};
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = wb_done;
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        wb_do = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {wb_done, avm_write, avm_address, avm_writedata, avm_byteenable, avm_burstcount}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h1000, 2'd1, 4'hF, 4'h0, 56'h00000011223344, 0, 0);
        send(32'h2003, 2'd2, 4'h8, 4'h7, 56'h00000000CCBBAA, 0, 0);
        send(32'h3000, 2'd2, 4'hF, 4'hF, 56'h0123456789ABCD, 4, 2);
        send(32'h4001, 2'd0, 4'hF, 4'hF, 56'hFFFFFFFFFFFFFF, 0, 0);
        send(32'h5002, 2'd3, 4'hC, 4'h0, 56'hA1B2C3D4E5F607, 1, 0);
        // Abort a burst while its second beat is stalled.
        model(32'h6000, 2'd2, 4'hF, 4'hF, 56'h11111122222222, cyc + 1);
        stall_q.push_back(0);
        stall_q.push_back(1000);
        {wb_addr, wb_len, wb_be0, wb_be1, wb_data} = {32'h6000, 2'd2, 4'hF, 4'hF, 56'h11111122222222};
        wb_do = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("abort_in_beat1", 64'(avm_write), 1);
        rst_n = 1'b0;
        wb_do = 1'b0;
        #1;
        chk("abort_write_async", 64'(avm_write), 0);
        chk("abort_no_done", 64'(wb_done), 0);
        beat_q.delete();
        txn_q.delete();
        stall_q.delete();
        have_beat  = 0;
        stall_left = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'h7004, 2'd1, 4'h3, 4'h0, 56'h000000DEADBEEF, 0, 0);
        for (int n = 0; n < 60; n++) begin
            send($urandom, 2'($urandom), 4'($urandom), 4'($urandom), {24'($urandom), $urandom},
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                 ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(beat_q.size() + txn_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
